// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-memory request handshake, redirect/halt
// control and the decode-side view of the prefetch queue head.
// The fetch unit drives it through the master modport; the cache and
// decode stage (or a testbench) sit on the slave modport.
interface fetch_unit_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // instruction memory handshake
    logic             ihit;
    logic [31:0]      imemload;
    logic             imemREN;
    logic [31:0]      imemaddr;

    // control-flow control
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             halt;

    // decode side
    logic             deq;
    logic             instr_valid;
    logic [31:0]      instr;
    logic [31:0]      instr_pc;
    logic [31:0]      instr_npc;
    logic [CNT_W-1:0] count;

    modport master (
        input  ihit, imemload, redirect, redirect_pc, halt, deq,
        output imemREN, imemaddr, instr_valid, instr, instr_pc, instr_npc, count
    );

    modport slave (
        output ihit, imemload, redirect, redirect_pc, halt, deq,
        input  imemREN, imemaddr, instr_valid, instr, instr_pc, instr_npc, count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues instruction-memory reads
// and buffers {instruction, PC} pairs in a DEPTH-entry circular prefetch
// queue so fetch can run ahead of decode. Supports redirect/flush and a
// permanent halt (cleared only by reset).
//
// Optional feature macro: FETCH_BYPASS_EN
//   Defined   - on an empty queue, a fetched word is presented on the instr*
//               outputs in the same cycle it arrives; if decode consumes it
//               that cycle it is never written into the queue.
//   Undefined - instr* outputs come only from registered queue entries
//               (one-cycle latency from ihit to instr_valid).
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          DEPTH   = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    fetch_unit_if.master bus
);
    localparam int               PTR_W = $clog2(DEPTH);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    localparam logic [0:0] FETCH  = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;

    logic [0:0]       state;
    logic [31:0]      pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [31:0]      mem_instr [DEPTH];
    logic [31:0]      mem_pc    [DEPTH];

    logic             fetching;
    logic             empty;
    logic             req;
    logic             redirect_act;
    logic             hit;
    logic             bypass;
    logic             enq;
    logic             pop;

    logic             head_valid;
    logic [31:0]      head_instr;
    logic [31:0]      head_pc;

    // The low two bits of the redirect target are architecturally ignored.
    logic             unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // Queue/handshake control decode for this cycle.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        fetching     = (state == FETCH);
        empty        = (count == '0);
        req          = fetching && (count != FULL);
        redirect_act = fetching && bus.redirect;
        hit          = req && bus.ihit && !redirect_act;
`ifdef FETCH_BYPASS_EN
        bypass       = hit && empty;
`else
        bypass       = 1'b0;
`endif
        pop          = bus.deq && !empty && !redirect_act;
        enq          = hit && !(bypass && bus.deq);
    end

    // Head-of-queue view presented to decode (zeroed while empty).
    always_comb begin
        head_valid = 1'b0;
        head_instr = '0;
        head_pc    = '0;
        if (!empty) begin
            head_valid = 1'b1;
            head_instr = mem_instr[rd_ptr];
            head_pc    = mem_pc[rd_ptr];
        end
`ifdef FETCH_BYPASS_EN
        else if (bypass) begin
            head_valid = 1'b1;
            head_instr = bus.imemload;
            head_pc    = pc;
        end
`endif
    end

    assign bus.imemREN     = req;
    assign bus.imemaddr    = pc;
    assign bus.count       = count;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_instr;
    assign bus.instr_pc    = head_pc;
    assign bus.instr_npc   = head_pc + 32'd4;

    // Run/halt state: halt is sticky until reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
        end else if (fetching && bus.halt) begin
            state <= HALTED;
        end
    end

    // Program counter: redirect wins over sequential advance.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc <= PC_INIT;
        end else if (redirect_act) begin
            pc <= {bus.redirect_pc[31:2], 2'b00};
        end else if (hit) begin
            pc <= pc + 32'd4;
        end
    end

    // Queue pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_act) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage write port.
    // NOTE: the storage array has no reset; entry validity is tracked by count, so only control state is reset.
    always_ff @(posedge CLK) begin
        if (enq) begin
            mem_instr[wr_ptr] <= bus.imemload;
            mem_pc[wr_ptr]    <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (DEPTH = 4, PC_INIT = 0x40).
// Directed table, hand-written multi-cycle sequences, then randomized
// stimulus compared against a queue-based reference model.
module tb_fetch_unit;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] PC_INIT = 32'h0000_0040;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    fetch_unit_if #(.DEPTH(DEPTH)) bus ();

    fetch_unit #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs just after a rising edge, then move to the falling edge to sample.
    task automatic drive(input logic ih, input logic [31:0] ld, input logic rd,
                         input logic [31:0] rp, input logic hl, input logic dq);
        bus.ihit        = ih;
        bus.imemload    = ld;
        bus.redirect    = rd;
        bus.redirect_pc = rp;
        bus.halt        = hl;
        bus.deq         = dq;
        @(negedge clk);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    bit          m_halted;

    function automatic void model_reset();
        m_q.delete();
        m_pc     = PC_INIT;
        m_halted = 1'b0;
    endfunction

    function automatic bit model_ren();
        return !m_halted && (m_q.size() < DEPTH);
    endfunction

    function automatic bit model_hit();
        return model_ren() && bus.ihit && !bus.redirect;
    endfunction

    task automatic model_compare(input string tag);
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        bit          byp;
        byp     = BYP && model_hit() && (m_q.size() == 0);
        e_valid = (m_q.size() != 0) || byp;
        e_instr = 32'h0;
        e_pc    = 32'h0;
        if (m_q.size() != 0) begin
            e_instr = m_q[0].instr;
            e_pc    = m_q[0].pc;
        end else if (byp) begin
            e_instr = bus.imemload;
            e_pc    = m_pc;
        end
        check({tag, " imemREN"},     {31'h0, bus.imemREN},     {31'h0, model_ren()});
        check({tag, " imemaddr"},    bus.imemaddr,             m_pc);
        check({tag, " instr_valid"}, {31'h0, bus.instr_valid}, {31'h0, e_valid});
        check({tag, " instr"},       bus.instr,                e_instr);
        check({tag, " instr_pc"},    bus.instr_pc,             e_pc);
        check({tag, " instr_npc"},   bus.instr_npc,            e_pc + 32'd4);
        check({tag, " count"},       32'(bus.count),           m_q.size());
    endtask

    function automatic void model_step();
        bit hit;
        bit consumed;
        if (!m_halted && bus.redirect) begin
            m_q.delete();
            m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            hit      = model_hit();
            consumed = BYP && hit && (m_q.size() == 0) && bus.deq;
            if (bus.deq && m_q.size() != 0) void'(m_q.pop_front());
            if (hit) begin
                if (!consumed) m_q.push_back('{instr: bus.imemload, pc: m_pc});
                m_pc = m_pc + 32'd4;
            end
        end
        if (!m_halted && bus.halt) m_halted = 1'b1;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic        ihit;
        logic [31:0] load;
        logic        redirect;
        logic [31:0] rpc;
        logic        deq;
        logic        e_ren;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        int          e_count;
    } vec_t;

    function automatic vec_t mk(logic ih, logic [31:0] ld, logic rd, logic [31:0] rp, logic dq,
                                logic ren, logic [31:0] addr, logic v, logic [31:0] ins,
                                logic [31:0] ipc, int cnt);
        vec_t r;
        r.ihit = ih;  r.load = ld;   r.redirect = rd; r.rpc = rp;    r.deq = dq;
        r.e_ren = ren; r.e_addr = addr; r.e_valid = v; r.e_instr = ins; r.e_pc = ipc;
        r.e_count = cnt;
        return r;
    endfunction

    vec_t vecs[15];

    initial begin
        // Each row: inputs for the cycle, outputs expected before the next edge.
        vecs[0]  = mk(1, 32'h1111_0000, 0, 0, 0, 1, 32'h40, BYP, BYP ? 32'h1111_0000 : 32'h0, BYP ? 32'h40 : 32'h0, 0);
        vecs[1]  = mk(1, 32'h1111_0001, 0, 0, 0, 1, 32'h44, 1, 32'h1111_0000, 32'h40, 1);
        vecs[2]  = mk(1, 32'h1111_0002, 0, 0, 0, 1, 32'h48, 1, 32'h1111_0000, 32'h40, 2);
        vecs[3]  = mk(1, 32'h1111_0003, 0, 0, 0, 1, 32'h4C, 1, 32'h1111_0000, 32'h40, 3);
        vecs[4]  = mk(1, 32'hBAD0_0004, 0, 0, 0, 0, 32'h50, 1, 32'h1111_0000, 32'h40, 4);
        vecs[5]  = mk(0, 32'h0,         0, 0, 1, 0, 32'h50, 1, 32'h1111_0000, 32'h40, 4);
        vecs[6]  = mk(1, 32'h1111_0004, 0, 0, 0, 1, 32'h50, 1, 32'h1111_0001, 32'h44, 3);
        vecs[7]  = mk(0, 32'h0,         0, 0, 0, 0, 32'h54, 1, 32'h1111_0001, 32'h44, 4);
        vecs[8]  = mk(0, 32'h0,         0, 0, 1, 0, 32'h54, 1, 32'h1111_0001, 32'h44, 4);
        vecs[9]  = mk(1, 32'hDEAD_BEEF, 1, 32'h0000_1003, 1, 1, 32'h54, 1, 32'h1111_0002, 32'h48, 3);
        vecs[10] = mk(0, 32'h0,         0, 0, 0, 1, 32'h1000, 0, 32'h0, 32'h0, 0);
        vecs[11] = mk(1, 32'h1111_0005, 0, 0, 0, 1, 32'h1000, BYP, BYP ? 32'h1111_0005 : 32'h0, BYP ? 32'h1000 : 32'h0, 0);
        vecs[12] = mk(0, 32'h0,         0, 0, 0, 1, 32'h1004, 1, 32'h1111_0005, 32'h1000, 1);
        vecs[13] = mk(0, 32'h0,         0, 0, 1, 1, 32'h1004, 1, 32'h1111_0005, 32'h1000, 1);
        vecs[14] = mk(0, 32'h0,         0, 0, 0, 1, 32'h1004, 0, 32'h0, 32'h0, 0);

        // ---- reset state, with ihit held high (must be ignored) ----
        nrst = 1'b1;
        bus.ihit = 1'b1; bus.imemload = 32'h5555_5555; bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0; bus.halt = 1'b0; bus.deq = 1'b0;
        #2 nrst = 1'b0;
        @(negedge clk);
        check("rst imemaddr",    bus.imemaddr, PC_INIT);
        check("rst imemREN",     {31'h0, bus.imemREN}, 32'h1);
        check("rst instr_valid", {31'h0, bus.instr_valid}, 32'h0);
        check("rst instr",       bus.instr, 32'h0);
        check("rst instr_pc",    bus.instr_pc, 32'h0);
        check("rst instr_npc",   bus.instr_npc, 32'h4);
        check("rst count",       32'(bus.count), 32'h0);
        cyc();
        @(negedge clk);
        check("rst hold imemaddr", bus.imemaddr, PC_INIT);
        check("rst hold count",    32'(bus.count), 32'h0);
        cyc();
        nrst = 1'b1;

        // ---- table: fill, full, deq/refill, redirect discard ----
        for (int i = 0; i < 15; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(vecs[i].ihit, vecs[i].load, vecs[i].redirect, vecs[i].rpc, 1'b0, vecs[i].deq);
            check({t, " imemREN"},     {31'h0, bus.imemREN},     {31'h0, vecs[i].e_ren});
            check({t, " imemaddr"},    bus.imemaddr,             vecs[i].e_addr);
            check({t, " instr_valid"}, {31'h0, bus.instr_valid}, {31'h0, vecs[i].e_valid});
            check({t, " instr"},       bus.instr,                vecs[i].e_instr);
            check({t, " instr_pc"},    bus.instr_pc,             vecs[i].e_pc);
            check({t, " instr_npc"},   bus.instr_npc,            vecs[i].e_pc + 32'd4);
            check({t, " count"},       32'(bus.count),           vecs[i].e_count);
            cyc();
        end

        // ---- halt with two entries queued ----
        do_reset();
        drive(0, 0, 1, 32'h18, 0, 0); cyc();
        drive(1, 32'hA000_0018, 0, 0, 0, 0);
        check("halt addr0", bus.imemaddr, 32'h18);
        cyc();
        drive(1, 32'hA000_001C, 0, 0, 0, 0);
        check("halt addr1", bus.imemaddr, 32'h1C);
        cyc();
        drive(0, 0, 0, 0, 1, 0);
        check("halt req before", {31'h0, bus.imemREN}, 32'h1);
        check("halt count2", 32'(bus.count), 32'h2);
        cyc();
        drive(1, 32'hBAD0_0020, 0, 0, 0, 0);
        check("halted imemREN", {31'h0, bus.imemREN}, 32'h0);
        check("halted addr", bus.imemaddr, 32'h20);
        cyc();
        drive(0, 0, 0, 0, 0, 1);
        check("halted count", 32'(bus.count), 32'h2);
        check("drain0 pc", bus.instr_pc, 32'h18);
        check("drain0 instr", bus.instr, 32'hA000_0018);
        cyc();
        drive(0, 0, 0, 0, 0, 1);
        check("drain1 pc", bus.instr_pc, 32'h1C);
        check("drain1 npc", bus.instr_npc, 32'h20);
        cyc();
        drive(1, 32'hBAD0_0200, 1, 32'h200, 0, 0);
        check("drained valid", {31'h0, bus.instr_valid}, 32'h0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        check("redir ignored addr", bus.imemaddr, 32'h20);
        check("redir ignored req", {31'h0, bus.imemREN}, 32'h0);
        check("redir ignored count", 32'(bus.count), 32'h0);
        cyc();

        // ---- 3-cycle ihit latency and PC wrap ----
        do_reset();
        drive(0, 0, 1, 32'hFFFF_FFF8, 0, 0); cyc();
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            a = 32'hFFFF_FFF8 + 32'(4 * k);
            for (int s = 0; s < 3; s++) begin
                drive(0, 0, 0, 0, 0, 0);
                check($sformatf("stall%0d.%0d addr", k, s), bus.imemaddr, a);
                cyc();
            end
            drive(1, 32'hC000_0000 + 32'(k), 0, 0, 0, 0);
            check($sformatf("hit%0d addr", k), bus.imemaddr, a);
            cyc();
        end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            a = 32'hFFFF_FFF8 + 32'(4 * k);
            drive(0, 0, 0, 0, 0, 1);
            check($sformatf("wrap%0d count", k), 32'(bus.count), 32'(3 - k));
            check($sformatf("wrap%0d pc", k), bus.instr_pc, a);
            check($sformatf("wrap%0d npc", k), bus.instr_npc, a + 32'd4);
            check($sformatf("wrap%0d instr", k), bus.instr, 32'hC000_0000 + 32'(k));
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0);
        check("wrap next addr", bus.imemaddr, 32'h4);
        check("wrap empty", 32'(bus.count), 32'h0);
        cyc();

        // ---- empty-queue hit with same-cycle deq ----
        do_reset();
        drive(1, 32'h2001_0005, 0, 0, 0, 1);
        check("byp valid", {31'h0, bus.instr_valid}, {31'h0, BYP});
        check("byp instr", bus.instr, BYP ? 32'h2001_0005 : 32'h0);
        check("byp pc", bus.instr_pc, BYP ? 32'h40 : 32'h0);
        cyc();
        drive(0, 0, 0, 0, 0, 0);
        check("byp next valid", {31'h0, bus.instr_valid}, {31'h0, !BYP});
        check("byp next count", 32'(bus.count), BYP ? 32'h0 : 32'h1);
        check("byp next instr", bus.instr, BYP ? 32'h0 : 32'h2001_0005);
        check("byp next addr", bus.imemaddr, 32'h44);
        cyc();

        // ---- randomized run against the reference model ----
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rp;
            rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            if ($urandom_range(0, 199) == 0) begin
                // asynchronous reset mid-cycle: outputs return to reset values at once
                bus.ihit = 1'b1;
                #1 nrst = 1'b0;
                model_reset();
                @(negedge clk);
                model_compare("rand rst");
                cyc();
                nrst = 1'b1;
            end else begin
                drive($urandom_range(0, 99) < 65, $urandom, $urandom_range(0, 99) < 4, rp,
                      $urandom_range(0, 299) == 0, $urandom_range(0, 99) < 45);
                model_compare("rand");
                model_step();
                cyc();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the pipelined processor.
- Owns the PC register and the instruction-memory request handshake on the datapath cache interface signals.
- Buffers fetched instructions with their PCs in a DEPTH-entry prefetch queue, so fetch runs ahead of decode.
- Supports redirect/flush (branch, jump, jr) and halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
DEPTH, 4, prefetch queue entries; power of 2, minimum 2.

Ports:
CLK  in  1  clock, all state updates on rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  imemload valid for current imemaddr this cycle
imemload  in  32  instruction word from cache
imemREN  out  1  instruction read request
imemaddr  out  32  fetch address (current PC)
redirect  in  1  flush queue and restart fetch at redirect_pc
redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced to 00
halt  in  1  stop fetching permanently (until reset)
deq  in  1  decode consumes head entry this cycle
instr_valid  out  1  head entry valid
instr  out  32  head instruction word
instr_pc  out  32  PC of head instruction
instr_npc  out  32  instr_pc + 4 (for jal link / branch base)
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, nRST low):
  - PC = PC_INIT, queue empty (rd_ptr = wr_ptr = 0, count = 0), state = FETCH.
  - Outputs during reset: imemaddr = PC_INIT, imemREN = 1, instr_valid = 0, instr = 0, instr_pc = 0, instr_npc = 4, count = 0.
- States: FETCH, HALTED.
- FETCH:
  - imemREN = (count < DEPTH). imemaddr = PC, held stable until ihit or redirect.
  - ihit with imemREN: write {imemload, PC} at wr_ptr; PC <= PC + 4 (32-bit wrap 0xFFFFFFFC -> 0); wr_ptr++.
  - ihit while imemREN = 0 is ignored.
- Queue:
  - Circular buffer, pointers wrap modulo DEPTH.
  - instr_valid = (count != 0); head fields are registered entries (no bypass unless the optional feature is enabled).
  - deq with instr_valid: rd_ptr++. deq with count = 0 is ignored.
  - Simultaneous enqueue and dequeue: count unchanged.
  - Full (count = DEPTH): imemREN = 0, no enqueue; a deq that cycle frees one slot, and the request resumes next cycle.
  - Latency: ihit in cycle N -> instr_valid in cycle N+1 (empty-queue case).
- Redirect (any state except HALTED, highest priority):
  - Next edge: queue flushed (count = 0, pointers = 0) and PC <= {redirect_pc[31:2], 2'b00}.
  - Same-cycle ihit data and deq are discarded.
  - From the cycle after redirect, imemaddr = new PC.
- Halt:
  - halt sampled high in FETCH -> HALTED at next edge.
  - A same-cycle redirect still loads the PC and flushes; a same-cycle ihit is still enqueued if no redirect.
- HALTED:
  - imemREN = 0, PC frozen, redirect ignored, ihit ignored.
  - Queue remains drainable by deq.
  - Exit only via nRST.
- Reset mid-operation: all state returns to reset values immediately; in-flight request abandoned.
- count always equals enqueues minus dequeues since the last flush; it never exceeds DEPTH and never goes negative.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when count = 0 and ihit with imemREN (no redirect), instr_valid = 1 the same cycle, with instr = imemload, instr_pc = PC, instr_npc = PC + 4 combinationally. If deq is also asserted that cycle, the word is consumed and not written into the queue (count stays 0); otherwise it is enqueued normally. Latency becomes zero cycles when empty.
- Undefined: no combinational path from ihit/imemload to the instr* outputs; one-cycle latency as above.

Test Plan:
- Reset with PC_INIT = 0x0000_0040, ihit held 1, deq = 0 -> imemaddr sequence 0x40, 0x44, 0x48, 0x4C; after 4 hits imemREN = 0, count = 4, instr_pc = 0x40.
- Queue full (DEPTH = 4), deq pulsed one cycle -> count 4 -> 3; imemREN high the next cycle; ihit refills with PC 0x50; head advances to 0x44.
- Redirect with redirect_pc = 0x0000_1003 while count = 3 and ihit = 1 -> next cycle count = 0, imemaddr = 0x1000, instr_valid = 0, and the same-cycle ihit word never appears.
- halt asserted at PC 0x20 with 2 entries queued -> imemREN = 0 from the next cycle; two deqs drain instr_pc 0x18, 0x1C (example values); subsequent redirect to 0x200 ignored, imemaddr stays 0x20.
- ihit delayed 3 cycles per request -> imemaddr stable across stall cycles; entries arrive in order with correct instr_npc = instr_pc + 4; PC wrap from 0xFFFF_FFFC -> 0x0000_0000.
- FETCH_BYPASS_EN defined, empty queue, ihit with imemload = 0x2001_0005 and deq = 1 the same cycle -> instr_valid = 1, instr = 0x2001_0005 that cycle, count remains 0; without the macro, instr_valid = 0 that cycle and rises next cycle.
